// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, byte0 field positions and defaults for the PS/2 packet decoder
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_BYTE0     = 2'd1,
    ST_BYTE1     = 2'd2,
    ST_BYTE2     = 2'd3
  } ps2_state_t;

  localparam int PS2_B0_LEFT   = 0;
  localparam int PS2_B0_RIGHT  = 1;
  localparam int PS2_B0_MIDDLE = 2;
  localparam int PS2_B0_SYNC   = 3;
  localparam int PS2_B0_XSIGN  = 4;
  localparam int PS2_B0_YSIGN  = 5;
  localparam int PS2_B0_XOVF   = 6;
  localparam int PS2_B0_YOVF   = 7;

  localparam int PS2_TIMEOUT_DEFAULT = 54000;

  // 9-bit packet delta widened so that its negation (-(-256)) still fits
  function automatic logic signed [9:0] ps2_sext_delta(input logic [8:0] d);
    return $signed({d[8], d});
  endfunction

endpackage

// File: rtl/mouse_cursor_accum.sv
// rtl/mouse_cursor_accum.sv - one cursor axis: sign-extend, add and clamp a delta into a saturating position
module mouse_cursor_accum #(
  parameter int COORD_W  = 10,
  parameter int MAX_POS  = 639,
  parameter int INIT_POS = 320,
  parameter int DELTA_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      update,
  input  logic                      ovf,
  input  logic signed [DELTA_W-1:0] delta,
  output logic [COORD_W-1:0]        pos
);

  localparam int SUM_W = COORD_W + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_POS);

  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = $signed({2'b00, pos}) + $signed({{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta});
  end

  // an overflowed axis contributes nothing, so the position simply holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos <= COORD_W'(INIT_POS);
    end else if (update && !ovf) begin
      if (sum < 0)
        pos <= '0;
      else if (sum > MAX_S)
        pos <= MAX_S[COORD_W-1:0];
      else
        pos <= sum[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// rtl/ps2_mouse_packet_decoder.sv - frames 3-byte PS/2 mouse packets, decodes fields, drives a saturating cursor
// Optional inter-byte timeout abort: PS2_PKT_TIMEOUT_EN
module ps2_mouse_packet_decoder
  import ps2_pkg::*;
#(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int COORD_W        = 10,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_done,
  input  logic [7:0]         rx_data,
  input  logic               rx_data_valid,
  output logic               pkt_valid,
  output logic               btn_left,
  output logic               btn_right,
  output logic               btn_middle,
  output logic [8:0]         dx,
  output logic [8:0]         dy,
  output logic               x_ovf,
  output logic               y_ovf,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               sync_error
);

  ps2_state_t state;

  logic [2:0] b0_btn;
  logic       b0_xsign;
  logic       b0_ysign;
  logic       b0_xovf;
  logic       b0_yovf;
  logic [7:0] b1;

  logic              decode;
  logic              timeout;
  logic [8:0]        dx_next;
  logic [8:0]        dy_next;
  logic signed [9:0] dx_acc;
  logic signed [9:0] dy_acc;

  assign decode  = init_done && (state == ST_BYTE2) && rx_data_valid;
  assign dx_next = {b0_xsign, b1};
  assign dy_next = {b0_ysign, rx_data};
  assign dx_acc  = ps2_sext_delta(dx_next);
  // screen y grows downward while mouse dy is positive-up
  assign dy_acc  = -ps2_sext_delta(dy_next);

`ifdef PS2_PKT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;

  assign timeout = init_done && (state == ST_BYTE1 || state == ST_BYTE2) &&
                   !rx_data_valid && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n || !init_done || rx_data_valid || timeout ||
        !(state == ST_BYTE1 || state == ST_BYTE2))
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_WAIT_INIT;
      pkt_valid  <= 1'b0;
      sync_error <= 1'b0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      dx         <= '0;
      dy         <= '0;
      x_ovf      <= 1'b0;
      y_ovf      <= 1'b0;
      b0_btn     <= '0;
      b0_xsign   <= 1'b0;
      b0_ysign   <= 1'b0;
      b0_xovf    <= 1'b0;
      b0_yovf    <= 1'b0;
      b1         <= '0;
    end else begin
      pkt_valid  <= 1'b0;
      sync_error <= 1'b0;
      if (!init_done) begin
        state <= ST_WAIT_INIT;
      end else begin
        case (state)
          // the strobe in the first init_done cycle is the controller's ack
          ST_WAIT_INIT: state <= ST_BYTE0;
          ST_BYTE0: begin
            if (rx_data_valid) begin
              if (rx_data[PS2_B0_SYNC]) begin
                b0_btn   <= {rx_data[PS2_B0_MIDDLE], rx_data[PS2_B0_RIGHT], rx_data[PS2_B0_LEFT]};
                b0_xsign <= rx_data[PS2_B0_XSIGN];
                b0_ysign <= rx_data[PS2_B0_YSIGN];
                b0_xovf  <= rx_data[PS2_B0_XOVF];
                b0_yovf  <= rx_data[PS2_B0_YOVF];
                state    <= ST_BYTE1;
              end else begin
                sync_error <= 1'b1;
              end
            end
          end
          ST_BYTE1: begin
            if (timeout) begin
              sync_error <= 1'b1;
              state      <= ST_BYTE0;
            end else if (rx_data_valid) begin
              b1    <= rx_data;
              state <= ST_BYTE2;
            end
          end
          ST_BYTE2: begin
            if (timeout) begin
              sync_error <= 1'b1;
              state      <= ST_BYTE0;
            end else if (rx_data_valid) begin
              pkt_valid  <= 1'b1;
              btn_left   <= b0_btn[0];
              btn_right  <= b0_btn[1];
              btn_middle <= b0_btn[2];
              x_ovf      <= b0_xovf;
              y_ovf      <= b0_yovf;
              dx         <= dx_next;
              dy         <= dy_next;
              state      <= ST_BYTE0;
            end
          end
          default: state <= ST_WAIT_INIT;
        endcase
      end
    end
  end

  mouse_cursor_accum #(
    .COORD_W (COORD_W),
    .MAX_POS (SCREEN_W - 1),
    .INIT_POS(X_INIT),
    .DELTA_W (10)
  ) u_accum_x (
    .clk   (clk),
    .rst_n (rst_n),
    .update(decode),
    .ovf   (b0_xovf),
    .delta (dx_acc),
    .pos   (cursor_x)
  );

  mouse_cursor_accum #(
    .COORD_W (COORD_W),
    .MAX_POS (SCREEN_H - 1),
    .INIT_POS(Y_INIT),
    .DELTA_W (10)
  ) u_accum_y (
    .clk   (clk),
    .rst_n (rst_n),
    .update(decode),
    .ovf   (b0_yovf),
    .delta (dy_acc),
    .pos   (cursor_y)
  );

endmodule

// File: doc/ps2_mouse_packet_decoder.md
# ps2_mouse_packet_decoder

Consumes the byte stream from the PS/2 mouse controller after initialization completes. Frames the stream into standard 3-byte stream-mode packets and decodes button states and 9-bit signed X/Y deltas. Integrates the deltas into a saturating cursor position for the Paint drawing/VGA logic. Sits directly downstream of the controller's `rx_data` / `rx_data_valid` / `init_done` outputs.

## Interface
Parameters:
- `SCREEN_W`, 640: horizontal extent; cursor_x range is 0..SCREEN_W-1.
- `SCREEN_H`, 480: vertical extent; cursor_y range is 0..SCREEN_H-1.
- `X_INIT`, 320: cursor_x after reset.
- `Y_INIT`, 240: cursor_y after reset.
- `COORD_W`, 10: width of cursor coordinates.
- `TIMEOUT_CYCLES`, 54000: inter-byte gap (~2 ms @ 27 MHz) that aborts a partial packet; used only with the macro in Configuration.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock (27 MHz).
- `rst_n`  in  1  synchronous, active-low reset.
- `init_done`  in  1  controller finished init; level signal.
- `rx_data`  in  8  received byte.
- `rx_data_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `pkt_valid`  out  1  one-cycle pulse: new packet decoded.
- `btn_left`, `btn_right`, `btn_middle`  out  1 each  button states from the last packet.
- `dx`, `dy`  out  9 each  two's-complement deltas from the last packet (dy positive = up).
- `x_ovf`, `y_ovf`  out  1 each  overflow flags from the last packet.
- `cursor_x`, `cursor_y`  out  COORD_W each  cursor position (y grows downward).
- `sync_error`  out  1  one-cycle pulse: byte or partial packet discarded.

## Operation
- FSM states:
  - `WAIT_INIT`: reset state; all bytes ignored; go to `BYTE0` when `init_done`=1.
  - `BYTE0`: on a strobe, if `rx_data[3]`=1 latch the byte and go to `BYTE1`; otherwise pulse `sync_error` and stay in `BYTE0`.
  - `BYTE1`: on a strobe, latch X and go to `BYTE2`.
  - `BYTE2`: on a strobe, latch Y, decode the packet, go to `BYTE0`.
- `init_done`=0 in any state forces `WAIT_INIT` next cycle and discards any partial packet, with no `sync_error`.
- A strobe in the same cycle `init_done` first reads 1 is ignored (this is the controller's 0xFA ack).
- Byte 0 fields: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- Decode: `dx`={b0[4], b1}; `dy`={b0[5], b2}; buttons and overflow flags taken from b0.
- Cursor update: signed arithmetic at COORD_W+2 bits.
  - x' = clamp(x + dx, 0, SCREEN_W-1).
  - y' = clamp(y − dy, 0, SCREEN_H-1).
  - If an axis's overflow flag is set, that axis's delta counts as 0 for the cursor; raw `dx`/`dy` are still output.
- All outputs hold their values between packets.

## Timing
- Reset values: `pkt_valid`=0, `sync_error`=0, buttons=0, `dx`=`dy`=0, ovf flags=0, `cursor_x`=X_INIT, `cursor_y`=Y_INIT, state=`WAIT_INIT`.
- Latency: `pkt_valid`, decoded fields and the cursor all update on the clock edge following the third byte's strobe (1 cycle).
- Back-to-back strobes on consecutive cycles are accepted; no backpressure.
- `sync_error` is registered and asserts the cycle after the offending strobe or the timeout.
- Reset mid-packet: all state and outputs return to reset values; the next packet is framed from `BYTE0` once `init_done` is seen.

## Configuration
- `PS2_PKT_TIMEOUT_EN` defined:
  - A cycle counter runs while in `BYTE1`/`BYTE2` and clears on every strobe.
  - When it reaches TIMEOUT_CYCLES: go to `BYTE0`, pulse `sync_error`, drop the partial packet.
- `PS2_PKT_TIMEOUT_EN` undefined: no counter. Resynchronization relies only on the byte0 bit3 check.

## Structure
- Shared package `ps2_pkg`:
  - state encoding localparams;
  - byte0 bit-position constants (`PS2_B0_*`);
  - default TIMEOUT_CYCLES.
- Sub-module `mouse_cursor_accum`:
  - holds the cursor registers;
  - inputs: delta, overflow, update strobe;
  - applies the sign-extend/add/clamp for one axis;
  - instantiated twice (Y instance receives the negated delta).

## Test plan
- Reset, then `init_done`=1 with no bytes -> cursor (320,240), `pkt_valid` never asserted, buttons 0.
- Bytes 0x09, 0x05, 0x03 -> one `pkt_valid` pulse; `btn_left`=1, `dx`=5, `dy`=3, cursor (325,237).
- From reset, 0x38, 0xF6, 0xFB -> `dx`=0x1F6 (−10), `dy`=0x1FB (−5), cursor (310,245).
- Three packets 0x08, 0xFF, 0x00 (+255 each) -> cursor_x 575, then 639, then 639 (saturated). Packet 0x48, 0x10, 0x00 -> `x_ovf`=1, cursor unchanged.
- Byte 0x00 in `BYTE0` -> `sync_error` pulse, no `pkt_valid`. Following 0x0A, 0x00, 0x00 -> `btn_right`=1, cursor unchanged. Strobe coincident with `init_done` rising -> ignored.
- With `PS2_PKT_TIMEOUT_EN`: 0x08, 0x01, then idle TIMEOUT_CYCLES+1 -> `sync_error` pulse. Next 0x08, 0x02, 0x00 -> `dx`=2. Without the macro, the same stimulus yields a packet with `dx`=1, `dy`=8.
